// File: rtl/atm_txn_engine.sv
// ATM transaction responder: executes balance/withdraw/register/change-PIN requests against an internal card table.
// Optional per-card daily withdraw limit enabled by defining ATM_DAILY_LIMIT_EN.
module atm_txn_engine #(
    parameter int NUM_ACCTS   = 8,
    parameter int BAL_W       = 16,
    parameter int PIN_W       = 16,
    parameter int MAX_TRIES   = 3,
    parameter int DAILY_LIMIT = 500,
    // One spare code point so an out-of-range card id can always be presented.
    localparam int CARD_W     = $clog2(NUM_ACCTS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [CARD_W-1:0] req_card,
    input  logic [PIN_W-1:0]  req_pin,
    input  logic [BAL_W-1:0]  req_amount,
    input  logic [PIN_W-1:0]  req_new_pin,
    input  logic              day_tick,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [2:0]        resp_status,
    output logic [BAL_W-1:0]  resp_balance
);

    localparam int IDX_W  = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);

    localparam logic [1:0] OP_BAL = 2'b00;
    localparam logic [1:0] OP_WDR = 2'b01;
    localparam logic [1:0] OP_REG = 2'b10;
    localparam logic [1:0] OP_CHG = 2'b11;

    localparam logic [2:0] ST_OK          = 3'd0;
    localparam logic [2:0] ST_BAD_PIN     = 3'd1;
    localparam logic [2:0] ST_NO_CARD     = 3'd2;
    localparam logic [2:0] ST_LOCKED      = 3'd3;
    localparam logic [2:0] ST_INSUFF      = 3'd4;
    localparam logic [2:0] ST_ALREADY_REG = 3'd5;
    localparam logic [2:0] ST_LIMIT       = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_EXEC  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_req_ready;
    logic              r_resp_valid;
    logic [2:0]        r_resp_status;
    logic [BAL_W-1:0]  r_resp_balance;

    logic [1:0]        r_op;
    logic [CARD_W-1:0] r_card;
    logic [PIN_W-1:0]  r_pin_in;
    logic [BAL_W-1:0]  r_amount;
    logic [PIN_W-1:0]  r_new_pin;
    logic [2:0]        r_chk_status;

    logic              r_registered [NUM_ACCTS];
    logic              r_locked     [NUM_ACCTS];
    logic [FAIL_W-1:0] r_fail_cnt   [NUM_ACCTS];
    logic [BAL_W-1:0]  r_balance    [NUM_ACCTS];
    logic [PIN_W-1:0]  r_pin_tbl    [NUM_ACCTS];

    logic              w_accept;
    logic [IDX_W-1:0]  w_idx;
    logic              w_card_ok;
    logic              w_registered;
    logic              w_locked;
    logic [FAIL_W-1:0] w_fail_cnt;
    logic [FAIL_W-1:0] w_fail_inc;
    logic [BAL_W-1:0]  w_balance;
    logic [PIN_W-1:0]  w_pin_tbl;
    logic [BAL_W-1:0]  w_ok_balance;
    logic [2:0]        w_chk_status;
    logic              w_commit;
    logic              w_over_limit;

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_status  = r_resp_status;
    assign resp_balance = r_resp_balance;

    assign w_accept     = (r_state == S_IDLE) && req_valid;
    assign w_idx        = r_card[IDX_W-1:0];
    assign w_card_ok    = (r_card < CARD_W'(NUM_ACCTS));
    assign w_registered = r_registered[w_idx];
    assign w_locked     = r_locked[w_idx];
    assign w_fail_cnt   = r_fail_cnt[w_idx];
    assign w_balance    = r_balance[w_idx];
    assign w_pin_tbl    = r_pin_tbl[w_idx];
    assign w_commit     = (r_state == S_EXEC) && w_card_ok;
    assign w_fail_inc   = (w_fail_cnt == FAIL_W'(MAX_TRIES)) ? w_fail_cnt : (w_fail_cnt + FAIL_W'(1));

    // State register plus registered handshake flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_ready  <= (w_state_nxt == S_IDLE);
            r_resp_valid <= (w_state_nxt == S_RESP);
        end
    end

    // Next-state logic: fixed CHECK/EXEC pipeline, RESP holds until consumed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHECK: w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 2'd0;
            r_card    <= CARD_W'(0);
            r_pin_in  <= PIN_W'(0);
            r_amount  <= BAL_W'(0);
            r_new_pin <= PIN_W'(0);
        end else if (w_accept) begin
            r_op      <= req_op;
            r_card    <= req_card;
            r_pin_in  <= req_pin;
            r_amount  <= req_amount;
            r_new_pin <= req_new_pin;
        end
    end

    // Request evaluation in priority order; register ignores PIN and lock state.
    always_comb begin
        w_chk_status = ST_OK;
        if (!w_card_ok) begin
            w_chk_status = ST_NO_CARD;
        end else if (r_op == OP_REG) begin
            if (w_registered) begin
                w_chk_status = ST_ALREADY_REG;
            end else begin
                w_chk_status = ST_OK;
            end
        end else if (!w_registered) begin
            w_chk_status = ST_NO_CARD;
        end else if (w_locked) begin
            w_chk_status = ST_LOCKED;
        end else if (w_pin_tbl != r_pin_in) begin
            w_chk_status = ST_BAD_PIN;
        end else if ((r_op == OP_WDR) && (r_amount > w_balance)) begin
            w_chk_status = ST_INSUFF;
        end else if ((r_op == OP_WDR) && w_over_limit) begin
            w_chk_status = ST_LIMIT;
        end else begin
            w_chk_status = ST_OK;
        end
    end

    // Balance reported on a successful operation.
    always_comb begin
        w_ok_balance = w_balance;
        case (r_op)
            OP_WDR:  w_ok_balance = w_balance - r_amount;
            OP_REG:  w_ok_balance = r_amount;
            OP_BAL:  w_ok_balance = w_balance;
            OP_CHG:  w_ok_balance = w_balance;
            default: w_ok_balance = w_balance;
        endcase
    end

    // Check result captured in CHECK, response fields captured in EXEC and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_status   <= ST_OK;
            r_resp_status  <= ST_OK;
            r_resp_balance <= BAL_W'(0);
        end else begin
            if (r_state == S_CHECK) begin
                r_chk_status <= w_chk_status;
            end
            if (r_state == S_EXEC) begin
                r_resp_status  <= r_chk_status;
                r_resp_balance <= (r_chk_status == ST_OK) ? w_ok_balance : BAL_W'(0);
            end
        end
    end

    // Account table commit in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                r_registered[i] <= 1'b0;
                r_locked[i]     <= 1'b0;
                r_fail_cnt[i]   <= FAIL_W'(0);
                r_balance[i]    <= BAL_W'(0);
                r_pin_tbl[i]    <= PIN_W'(0);
            end
        end else if (w_commit) begin
            case (r_chk_status)
                ST_OK: begin
                    case (r_op)
                        OP_REG: begin
                            r_registered[w_idx] <= 1'b1;
                            r_locked[w_idx]     <= 1'b0;
                            r_fail_cnt[w_idx]   <= FAIL_W'(0);
                            r_pin_tbl[w_idx]    <= r_pin_in;
                            r_balance[w_idx]    <= r_amount;
                        end
                        OP_WDR: begin
                            r_balance[w_idx]  <= w_balance - r_amount;
                            r_fail_cnt[w_idx] <= FAIL_W'(0);
                        end
                        OP_CHG: begin
                            r_pin_tbl[w_idx]  <= r_new_pin;
                            r_fail_cnt[w_idx] <= FAIL_W'(0);
                        end
                        default: r_fail_cnt[w_idx] <= FAIL_W'(0);
                    endcase
                end
                ST_BAD_PIN: begin
                    r_fail_cnt[w_idx] <= w_fail_inc;
                    if (w_fail_inc == FAIL_W'(MAX_TRIES)) begin
                        r_locked[w_idx] <= 1'b1;
                    end
                end
                ST_INSUFF, ST_LIMIT: r_fail_cnt[w_idx] <= FAIL_W'(0);
                default: ;
            endcase
        end
    end

`ifdef ATM_DAILY_LIMIT_EN
    logic [BAL_W-1:0] r_day_total [NUM_ACCTS];
    logic [BAL_W:0]   w_day_sum;

    assign w_day_sum    = {1'b0, r_day_total[w_idx]} + {1'b0, r_amount};
    assign w_over_limit = (w_day_sum > (BAL_W + 1)'(DAILY_LIMIT));

    // Daily withdraw totals; the day boundary clear wins over a same-cycle commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                r_day_total[i] <= BAL_W'(0);
            end
        end else if (day_tick) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                r_day_total[i] <= BAL_W'(0);
            end
        end else if (w_commit && (r_chk_status == ST_OK) && (r_op == OP_WDR)) begin
            r_day_total[w_idx] <= w_day_sum[BAL_W-1:0];
        end
    end
`else
    localparam int unused_daily_limit = DAILY_LIMIT;
    logic w_unused_day_tick;

    assign w_unused_day_tick = day_tick;
    assign w_over_limit      = 1'b0;
`endif

endmodule

// File: tb/tb_atm_txn_engine.sv
// Directed self-checking bench for atm_txn_engine with hand-computed expectations.
module tb_atm_txn_engine;

    localparam logic [2:0] ST_OK          = 3'd0;
    localparam logic [2:0] ST_BAD_PIN     = 3'd1;
    localparam logic [2:0] ST_NO_CARD     = 3'd2;
    localparam logic [2:0] ST_LOCKED      = 3'd3;
    localparam logic [2:0] ST_INSUFF      = 3'd4;
    localparam logic [2:0] ST_ALREADY_REG = 3'd5;
    localparam logic [2:0] ST_LIMIT       = 3'd6;

    localparam logic [1:0] OP_BAL = 2'b00;
    localparam logic [1:0] OP_WDR = 2'b01;
    localparam logic [1:0] OP_REG = 2'b10;
    localparam logic [1:0] OP_CHG = 2'b11;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        req_valid   = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op      = 2'd0;
    logic [3:0]  req_card    = 4'd0;
    logic [15:0] req_pin     = 16'd0;
    logic [15:0] req_amount  = 16'd0;
    logic [15:0] req_new_pin = 16'd0;
    logic        day_tick    = 1'b0;
    logic        resp_valid;
    logic        resp_ready  = 1'b0;
    logic [2:0]  resp_status;
    logic [15:0] resp_balance;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    atm_txn_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_card     (req_card),
        .req_pin      (req_pin),
        .req_amount   (req_amount),
        .req_new_pin  (req_new_pin),
        .day_tick     (day_tick),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_status  (resp_status),
        .resp_balance (resp_balance)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Present a request and return #1 after its accept edge.
    task automatic drive_req(input logic [1:0] op, input logic [3:0] card, input logic [15:0] pin,
                             input logic [15:0] amt, input logic [15:0] new_pin);
        int n;
        req_op      = op;
        req_card    = card;
        req_pin     = pin;
        req_amount  = amt;
        req_new_pin = new_pin;
        req_valid   = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) check_eq("req_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accept edge.
    task automatic wait_resp(output int latency);
        latency = 1;
        while (!resp_valid && latency < 20) begin
            @(posedge clk);
            #1;
            latency++;
        end
        if (!resp_valid) check_eq("resp_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [1:0] op, input logic [3:0] card,
                       input logic [15:0] pin, input logic [15:0] amt, input logic [15:0] new_pin,
                       input logic [2:0] exp_st, input logic [15:0] exp_bal);
        int l;
        drive_req(op, card, pin, amt, new_pin);
        wait_resp(l);
        check_eq({tag, "_status"}, {29'd0, resp_status}, {29'd0, exp_st});
        check_eq({tag, "_balance"}, {16'd0, resp_balance}, {16'd0, exp_bal});
        ack_resp();
    endtask

    initial begin
        logic [15:0] hold_bal;

        // Reset
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_resp_status", {29'd0, resp_status}, 32'd0);
        check_eq("rst_resp_balance", {16'd0, resp_balance}, 32'd0);

        // Register card 2 with latency check, then duplicate register
        drive_req(OP_REG, 4'd2, 16'h1234, 16'd300, 16'd0);
        check_eq("busy_req_ready", {31'd0, req_ready}, 32'd0);
        wait_resp(lat);
        check_eq("reg_latency", lat, 32'd3);
        check_eq("reg_status", {29'd0, resp_status}, {29'd0, ST_OK});
        check_eq("reg_balance", {16'd0, resp_balance}, 32'd300);
        ack_resp();
        check_eq("post_ack_req_ready", {31'd0, req_ready}, 32'd1);
        txn("reg_dup", OP_REG, 4'd2, 16'h9999, 16'd50, 16'd0, ST_ALREADY_REG, 16'd0);

        // Withdraw / funds
        txn("wdr100", OP_WDR, 4'd2, 16'h1234, 16'd100, 16'd0, ST_OK, 16'd200);
        txn("wdr250", OP_WDR, 4'd2, 16'h1234, 16'd250, 16'd0, ST_INSUFF, 16'd0);
        txn("bal200", OP_BAL, 4'd2, 16'h1234, 16'd0, 16'd0, ST_OK, 16'd200);
        txn("wdr0", OP_WDR, 4'd2, 16'h1234, 16'd0, 16'd0, ST_OK, 16'd200);

        // Card 3: PIN change, exact-balance withdraw, fail counter cleared by a good PIN
        txn("reg3", OP_REG, 4'd3, 16'hBEEF, 16'd50, 16'd0, ST_OK, 16'd50);
        txn("chg3", OP_CHG, 4'd3, 16'hBEEF, 16'd0, 16'hCAFE, ST_OK, 16'd50);
        txn("old_pin3", OP_BAL, 4'd3, 16'hBEEF, 16'd0, 16'd0, ST_BAD_PIN, 16'd0);
        txn("chg3_same", OP_CHG, 4'd3, 16'hCAFE, 16'd0, 16'hCAFE, ST_OK, 16'd50);
        txn("wdr_all3", OP_WDR, 4'd3, 16'hCAFE, 16'd50, 16'd0, ST_OK, 16'd0);
        txn("wdr_empty3", OP_WDR, 4'd3, 16'hCAFE, 16'd1, 16'd0, ST_INSUFF, 16'd0);
        txn("bad3_a", OP_BAL, 4'd3, 16'h0000, 16'd0, 16'd0, ST_BAD_PIN, 16'd0);
        txn("bad3_b", OP_BAL, 4'd3, 16'h0000, 16'd0, 16'd0, ST_BAD_PIN, 16'd0);
        txn("good3", OP_BAL, 4'd3, 16'hCAFE, 16'd0, 16'd0, ST_OK, 16'd0);
        txn("bad3_c", OP_BAL, 4'd3, 16'h0000, 16'd0, 16'd0, ST_BAD_PIN, 16'd0);
        txn("bad3_d", OP_BAL, 4'd3, 16'h0000, 16'd0, 16'd0, ST_BAD_PIN, 16'd0);
        txn("still_open3", OP_BAL, 4'd3, 16'hCAFE, 16'd0, 16'd0, ST_OK, 16'd0);

        // Lockout on card 2
        for (int i = 0; i < 3; i++) begin
            txn($sformatf("bad2_%0d", i), OP_WDR, 4'd2, 16'h1111, 16'd10, 16'd0, ST_BAD_PIN, 16'd0);
        end
        txn("locked2", OP_BAL, 4'd2, 16'h1234, 16'd0, 16'd0, ST_LOCKED, 16'd0);
        txn("locked2_chg", OP_CHG, 4'd2, 16'h1234, 16'd0, 16'h4321, ST_LOCKED, 16'd0);
        txn("locked2_reg", OP_REG, 4'd2, 16'h1234, 16'd10, 16'd0, ST_ALREADY_REG, 16'd0);

        // Unregistered and out-of-range cards
        txn("nocard5", OP_BAL, 4'd5, 16'h0000, 16'd0, 16'd0, ST_NO_CARD, 16'd0);
        txn("card8_reg", OP_REG, 4'd8, 16'h1234, 16'd100, 16'd0, ST_NO_CARD, 16'd0);
        txn("card15_wdr", OP_WDR, 4'd15, 16'h1234, 16'd1, 16'd0, ST_NO_CARD, 16'd0);

        // Daily limit (or its absence)
        txn("reg1", OP_REG, 4'd1, 16'h0001, 16'd1000, 16'd0, ST_OK, 16'd1000);
        txn("wdr400", OP_WDR, 4'd1, 16'h0001, 16'd400, 16'd0, ST_OK, 16'd600);
`ifdef ATM_DAILY_LIMIT_EN
        txn("wdr200_limit", OP_WDR, 4'd1, 16'h0001, 16'd200, 16'd0, ST_LIMIT, 16'd0);
        day_tick = 1'b1;
        @(posedge clk);
        #1;
        day_tick = 1'b0;
        txn("wdr200_newday", OP_WDR, 4'd1, 16'h0001, 16'd200, 16'd0, ST_OK, 16'd400);
        hold_bal = 16'd400;
`else
        txn("wdr200_nolimit", OP_WDR, 4'd1, 16'h0001, 16'd200, 16'd0, ST_OK, 16'd400);
        day_tick = 1'b1;
        @(posedge clk);
        #1;
        day_tick = 1'b0;
        txn("wdr200_tick", OP_WDR, 4'd1, 16'h0001, 16'd200, 16'd0, ST_OK, 16'd200);
        hold_bal = 16'd200;
`endif

        // Back-pressure: response must hold while resp_ready is low
        drive_req(OP_BAL, 4'd1, 16'h0001, 16'd0, 16'd0);
        wait_resp(lat);
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_valid", {31'd0, resp_valid}, 32'd1);
            check_eq("hold_status", {29'd0, resp_status}, {29'd0, ST_OK});
            check_eq("hold_balance", {16'd0, resp_balance}, {16'd0, hold_bal});
            check_eq("hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        ack_resp();

        // Reset in the middle of EXEC drops the transaction and clears the table
        drive_req(OP_BAL, 4'd3, 16'hCAFE, 16'd0, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("postrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        txn("postrst_card2", OP_BAL, 4'd2, 16'h1234, 16'd0, 16'd0, ST_NO_CARD, 16'd0);
        txn("postrst_reg1", OP_REG, 4'd1, 16'h0002, 16'd7, 16'd0, ST_OK, 16'd7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
